// File: rtl/interrupt_controller_if.sv
// Bus bundle between the IRQ controller and its surroundings (pins, control decode, sequencer).
// Pure wiring, no latency of its own.
// No backpressure: every signal is a level or a single-cycle strobe.
interface interrupt_controller_if #(
  parameter int NBR_IRQS = 8
);

  // Board-level IRQ pins (asynchronous to clk)
  logic [NBR_IRQS-1:0] irq_in;

  // Control-word decode and CPU state
  logic [7:0]          z_bus;
  logic                status_irq_en;
  logic                ctrl_irq_masks_wrt;   // active low
  logic                ctrl_int_vector_wrt;  // active low
  logic                ctrl_int_ack;         // active high
  logic                ctrl_clear_all_ints;  // active high

  // Results toward the sequencer and the data path
  logic                int_pending;
  logic [7:0]          int_vector;
  logic [7:0]          irq_masks;
  logic [7:0]          int_status;

  // Environment side: drives pins and control strobes, observes results
  modport master (
    output irq_in, z_bus, status_irq_en,
           ctrl_irq_masks_wrt, ctrl_int_vector_wrt, ctrl_int_ack, ctrl_clear_all_ints,
    input  int_pending, int_vector, irq_masks, int_status
  );

  // Controller side
  modport slave (
    input  irq_in, z_bus, status_irq_en,
           ctrl_irq_masks_wrt, ctrl_int_vector_wrt, ctrl_int_ack, ctrl_clear_all_ints,
    output int_pending, int_vector, irq_masks, int_status
  );

endinterface

// File: rtl/interrupt_controller.sv
// IRQ controller: synchronises IRQ pins, latches rising edges as pending, masks, arbitrates, hands a vector to microcode.
// Latency: pending bit sets SYNC_STAGES+1 edges after a pin rises; int_pending follows one edge later.
// No backpressure: the sequencer paces the handshake via vector write and ack strobes.
// Optional feature: define INT_CTRL_ROUND_ROBIN_EN for rotating priority (default is fixed, index 0 highest).
module interrupt_controller #(
  parameter int NBR_IRQS     = 8,
  parameter int SYNC_STAGES  = 2,
  parameter int VECTOR_SHIFT = 1
) (
  input logic                   clk,
  input logic                   arst_n,
  interrupt_controller_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    VECT = 2'd2
  } state_t;

  state_t              state_q;
  logic [NBR_IRQS-1:0] sync_q [SYNC_STAGES];
  logic [NBR_IRQS-1:0] prev_q;
  logic [NBR_IRQS-1:0] pending_q;
  logic [NBR_IRQS-1:0] pending_nxt;
  logic [NBR_IRQS-1:0] mask_q;
  logic [NBR_IRQS-1:0] rise;
  logic [NBR_IRQS-1:0] eligible;
  logic [NBR_IRQS-1:0] ack_mask;
  logic [2:0]          winner;
  logic [2:0]          idx_q;
  logic [7:0]          vec_nxt;
  logic                int_pending_q;
  logic [7:0]          int_vector_q;
  logic                ack_fire;

  // Synchroniser chain plus one history flop for edge detection
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= bus.irq_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise     = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign eligible = pending_q & mask_q & {NBR_IRQS{bus.status_irq_en}};
  assign ack_fire = (state_q == VECT) && bus.ctrl_int_ack && !bus.ctrl_clear_all_ints;

  // One-hot of the snapshotted index; built by compare so idx never indexes past NBR_IRQS
  always_comb begin
    ack_mask = '0;
    for (int i = 0; i < NBR_IRQS; i++) begin
      if (idx_q == 3'(i)) ack_mask[i] = 1'b1;
    end
  end

`ifdef INT_CTRL_ROUND_ROBIN_EN
  logic [2:0]            last_idx_q;
  logic [3:0]            start;
  logic [3:0]            off;
  logic [3:0]            sum;
  logic [2*NBR_IRQS-1:0] rot;

  // Rotating search: begin just after the last served index and wrap
  always_comb begin
    start = (last_idx_q == 3'(NBR_IRQS-1)) ? 4'd0 : ({1'b0, last_idx_q} + 4'd1);
    rot   = {eligible, eligible} >> start;
    off   = 4'd0;
    for (int i = NBR_IRQS - 1; i >= 0; i--) begin
      if (rot[i]) off = 4'(i);
    end
    sum = start + off;
    if (sum >= 4'(NBR_IRQS)) sum = sum - 4'(NBR_IRQS);
    winner = sum[2:0];
  end

  // Remember who was served last; clear_all deliberately leaves this alone
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      last_idx_q <= 3'(NBR_IRQS-1);
    end else if (ack_fire) begin
      last_idx_q <= idx_q;
    end
  end
`else
  // Fixed priority: lowest set index wins
  always_comb begin
    winner = 3'd0;
    for (int i = NBR_IRQS - 1; i >= 0; i--) begin
      if (eligible[i]) winner = 3'(i);
    end
  end
`endif

  assign vec_nxt = {5'd0, winner} << VECTOR_SHIFT;

  // Pending update: clears first, then new edges OR in so a coincident set always survives
  always_comb begin
    pending_nxt = pending_q;
    if (bus.ctrl_clear_all_ints) begin
      pending_nxt = '0;
    end else if (ack_fire) begin
      pending_nxt = pending_q & ~ack_mask;
    end
    pending_nxt = pending_nxt | rise;
  end

  // Pending and mask registers; a mask write takes effect from the following cycle
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      pending_q <= '0;
      mask_q    <= '0;
    end else begin
      pending_q <= pending_nxt;
      if (!bus.ctrl_irq_masks_wrt) mask_q <= bus.z_bus[NBR_IRQS-1:0];
    end
  end

  // Handshake FSM with registered int_pending, snapshot index and vector
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q       <= IDLE;
      int_pending_q <= 1'b0;
      idx_q         <= 3'd0;
      int_vector_q  <= 8'd0;
    end else if (bus.ctrl_clear_all_ints) begin
      state_q       <= IDLE;
      int_pending_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|eligible) begin
            state_q       <= REQ;
            int_pending_q <= 1'b1;
          end
        end
        REQ: begin
          if (eligible == '0) begin
            // Request vanished before the trap routine took it
            state_q       <= IDLE;
            int_pending_q <= 1'b0;
          end else if (!bus.ctrl_int_vector_wrt) begin
            state_q      <= VECT;
            idx_q        <= winner;
            int_vector_q <= vec_nxt;
          end
        end
        VECT: begin
          // Once the vector is taken the handshake always completes
          if (bus.ctrl_int_ack) begin
            state_q       <= IDLE;
            int_pending_q <= 1'b0;
          end
        end
        default: begin
          state_q       <= IDLE;
          int_pending_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.int_pending = int_pending_q;
  assign bus.int_vector  = int_vector_q;
  assign bus.irq_masks   = 8'(mask_q);
  assign bus.int_status  = 8'(pending_q);

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller: one task per scenario, inline checks, one summary line.
module tb_interrupt_controller;

  logic clk;
  logic arst_n;
  int   checks;
  int   passes;

  interrupt_controller_if #(.NBR_IRQS(8)) bus ();

  interrupt_controller #(
    .NBR_IRQS    (8),
    .SYNC_STAGES (2),
    .VECTOR_SHIFT(1)
  ) dut (
    .clk   (clk),
    .arst_n(arst_n),
    .bus   (bus)
  );

`ifdef INT_CTRL_ROUND_ROBIN_EN
  // irq 5 served last, so irq 6 comes before irq 2
  localparam logic [7:0] PRIO_VEC1    = 8'h0C;
  localparam logic [7:0] PRIO_STATUS1 = 8'h04;
  localparam logic [7:0] PRIO_VEC2    = 8'h04;
`else
  localparam logic [7:0] PRIO_VEC1    = 8'h04;
  localparam logic [7:0] PRIO_STATUS1 = 8'h40;
  localparam logic [7:0] PRIO_VEC2    = 8'h0C;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write_mask(input logic [7:0] m);
    bus.z_bus = m;
    bus.ctrl_irq_masks_wrt = 1'b0;
    tick(1);
    bus.ctrl_irq_masks_wrt = 1'b1;
  endtask

  task automatic pulse_vector();
    bus.ctrl_int_vector_wrt = 1'b0;
    tick(1);
    bus.ctrl_int_vector_wrt = 1'b1;
  endtask

  task automatic pulse_ack();
    bus.ctrl_int_ack = 1'b1;
    tick(1);
    bus.ctrl_int_ack = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (bus.int_pending !== 1'b0) $display("FAIL reset_pending got=%0b want=0", bus.int_pending); else passes++;
    checks++; if (bus.int_vector !== 8'h00) $display("FAIL reset_vector got=%h want=00", bus.int_vector); else passes++;
    checks++; if (bus.irq_masks !== 8'h00) $display("FAIL reset_masks got=%h want=00", bus.irq_masks); else passes++;
    checks++; if (bus.int_status !== 8'h00) $display("FAIL reset_status got=%h want=00", bus.int_status); else passes++;
    arst_n = 1'b1;
    tick(1);
  endtask

  task automatic test_single_irq();
    write_mask(8'h01);
    checks++; if (bus.irq_masks !== 8'h01) $display("FAIL mask_write got=%h want=01", bus.irq_masks); else passes++;
    bus.status_irq_en = 1'b1;
    bus.irq_in = 8'h01;
    tick(2);
    checks++; if (bus.int_status !== 8'h00) $display("FAIL early_status got=%h want=00", bus.int_status); else passes++;
    tick(1);
    checks++; if (bus.int_status !== 8'h01) $display("FAIL edge3_status got=%h want=01", bus.int_status); else passes++;
    checks++; if (bus.int_pending !== 1'b0) $display("FAIL edge3_pending got=%0b want=0", bus.int_pending); else passes++;
    tick(1);
    checks++; if (bus.int_pending !== 1'b1) $display("FAIL edge4_pending got=%0b want=1", bus.int_pending); else passes++;
    pulse_vector();
    checks++; if (bus.int_vector !== 8'h00) $display("FAIL irq0_vector got=%h want=00", bus.int_vector); else passes++;
    checks++; if (bus.int_pending !== 1'b1) $display("FAIL vect_pending got=%0b want=1", bus.int_pending); else passes++;
    pulse_ack();
    checks++; if (bus.int_pending !== 1'b0) $display("FAIL ack_pending got=%0b want=0", bus.int_pending); else passes++;
    checks++; if (bus.int_status !== 8'h00) $display("FAIL ack_status got=%h want=00", bus.int_status); else passes++;
    bus.irq_in = 8'h00;
    write_mask(8'h20);
    bus.irq_in = 8'h20;
    tick(4);
    checks++; if (bus.int_pending !== 1'b1) $display("FAIL irq5_pending got=%0b want=1", bus.int_pending); else passes++;
    pulse_vector();
    checks++; if (bus.int_vector !== 8'h0A) $display("FAIL irq5_vector got=%h want=0a", bus.int_vector); else passes++;
    pulse_ack();
    checks++; if (bus.int_pending !== 1'b0) $display("FAIL irq5_ack_pending got=%0b want=0", bus.int_pending); else passes++;
    bus.irq_in = 8'h00;
  endtask

  task automatic test_priority();
    write_mask(8'hFF);
    bus.irq_in = 8'h44;
    tick(4);
    checks++; if (bus.int_status !== 8'h44) $display("FAIL prio_status got=%h want=44", bus.int_status); else passes++;
    checks++; if (bus.int_pending !== 1'b1) $display("FAIL prio_pending got=%0b want=1", bus.int_pending); else passes++;
    pulse_vector();
    checks++; if (bus.int_vector !== PRIO_VEC1) $display("FAIL prio_vec1 got=%h want=%h", bus.int_vector, PRIO_VEC1); else passes++;
    pulse_ack();
    checks++; if (bus.int_pending !== 1'b0) $display("FAIL prio_ack_pending got=%0b want=0", bus.int_pending); else passes++;
    checks++; if (bus.int_status !== PRIO_STATUS1) $display("FAIL prio_ack_status got=%h want=%h", bus.int_status, PRIO_STATUS1); else passes++;
    tick(1);
    checks++; if (bus.int_pending !== 1'b1) $display("FAIL prio_rerise got=%0b want=1", bus.int_pending); else passes++;
    pulse_vector();
    checks++; if (bus.int_vector !== PRIO_VEC2) $display("FAIL prio_vec2 got=%h want=%h", bus.int_vector, PRIO_VEC2); else passes++;
    pulse_ack();
    checks++; if (bus.int_status !== 8'h00) $display("FAIL prio_final_status got=%h want=00", bus.int_status); else passes++;
    bus.irq_in = 8'h00;
  endtask

  task automatic test_mask_abort();
    bus.irq_in = 8'h08;
    tick(4);
    checks++; if (bus.int_pending !== 1'b1) $display("FAIL abort_req got=%0b want=1", bus.int_pending); else passes++;
    write_mask(8'h00);
    // old mask still governs the cycle of the write
    checks++; if (bus.int_pending !== 1'b1) $display("FAIL abort_oldmask got=%0b want=1", bus.int_pending); else passes++;
    tick(1);
    checks++; if (bus.int_pending !== 1'b0) $display("FAIL abort_idle got=%0b want=0", bus.int_pending); else passes++;
    checks++; if (bus.int_status !== 8'h08) $display("FAIL abort_status got=%h want=08", bus.int_status); else passes++;
    write_mask(8'h08);
    tick(1);
    checks++; if (bus.int_pending !== 1'b1) $display("FAIL abort_return got=%0b want=1", bus.int_pending); else passes++;
  endtask

  task automatic test_clear_collision();
    pulse_vector();
    checks++; if (bus.int_vector !== 8'h06) $display("FAIL clr_vector got=%h want=06", bus.int_vector); else passes++;
    bus.irq_in = 8'h0A;
    tick(2);
    bus.ctrl_clear_all_ints = 1'b1;
    tick(1);
    bus.ctrl_clear_all_ints = 1'b0;
    checks++; if (bus.int_pending !== 1'b0) $display("FAIL clr_pending got=%0b want=0", bus.int_pending); else passes++;
    checks++; if (bus.int_status !== 8'h02) $display("FAIL clr_status got=%h want=02", bus.int_status); else passes++;
    checks++; if (bus.int_vector !== 8'h06) $display("FAIL clr_vec_hold got=%h want=06", bus.int_vector); else passes++;
    // strobes outside their states are ignored
    pulse_vector();
    checks++; if (bus.int_vector !== 8'h06) $display("FAIL idle_vecwrt got=%h want=06", bus.int_vector); else passes++;
    pulse_ack();
    checks++; if (bus.int_status !== 8'h02) $display("FAIL idle_ack got=%h want=02", bus.int_status); else passes++;
    bus.ctrl_clear_all_ints = 1'b1;
    tick(1);
    bus.ctrl_clear_all_ints = 1'b0;
    checks++; if (bus.int_status !== 8'h00) $display("FAIL clr_all got=%h want=00", bus.int_status); else passes++;
    bus.irq_in = 8'h00;
  endtask

  task automatic test_reset_mid();
    write_mask(8'h10);
    bus.irq_in = 8'h10;
    tick(4);
    checks++; if (bus.int_pending !== 1'b1) $display("FAIL rmid_req got=%0b want=1", bus.int_pending); else passes++;
    pulse_vector();
    checks++; if (bus.int_vector !== 8'h08) $display("FAIL rmid_vector got=%h want=08", bus.int_vector); else passes++;
    #2;
    arst_n = 1'b0;
    #1;
    checks++; if (bus.int_pending !== 1'b0) $display("FAIL rmid_pending got=%0b want=0", bus.int_pending); else passes++;
    checks++; if (bus.int_vector !== 8'h00) $display("FAIL rmid_vec got=%h want=00", bus.int_vector); else passes++;
    checks++; if (bus.int_status !== 8'h00) $display("FAIL rmid_status got=%h want=00", bus.int_status); else passes++;
    #2;
    arst_n = 1'b1;
    tick(2);
    checks++; if (bus.int_status !== 8'h00) $display("FAIL held_early got=%h want=00", bus.int_status); else passes++;
    tick(1);
    checks++; if (bus.int_status !== 8'h10) $display("FAIL held_edge3 got=%h want=10", bus.int_status); else passes++;
    checks++; if (bus.int_pending !== 1'b0) $display("FAIL held_masked got=%0b want=0", bus.int_pending); else passes++;
  endtask

  initial begin
    checks = 0;
    passes = 0;
    arst_n = 1'b0;
    bus.irq_in = 8'h00;
    bus.z_bus = 8'h00;
    bus.status_irq_en = 1'b0;
    bus.ctrl_irq_masks_wrt = 1'b1;
    bus.ctrl_int_vector_wrt = 1'b1;
    bus.ctrl_int_ack = 1'b0;
    bus.ctrl_clear_all_ints = 1'b0;
    test_reset();
    test_single_irq();
    test_priority();
    test_mask_abort();
    test_clear_collision();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
